// File: rtl/wino_sched_pkg.sv
// rtl/wino_sched_pkg.sv - shared types and tile address helper for the Winograd kernel scheduler
package wino_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_FETCH,
      S_WAIT_LAST,
      S_DONE
   } sched_state_e;

   localparam int unsigned KSQ = 16;

   // Tiles are interleaved by channel within each kernel index.
   function automatic logic [31:0] tile_addr(
      input logic [31:0] kidx,
      input logic [31:0] ch,
      input logic [31:0] n_ch,
      input logic [31:0] base,
      input logic [31:0] ksq = KSQ
   );
      return base + (kidx * n_ch + ch) * ksq;
   endfunction

endpackage

// File: rtl/winograd_kernel_scheduler_rr_arbiter.sv
// rtl/winograd_kernel_scheduler_rr_arbiter.sv - N-request round-robin arbiter, pointer advances on grant
module rr_arbiter #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clock_i,
   input  logic          reset_ni,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic          grant_valid,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] cand;
   int            pos;

   // Scan from the far end so the request closest to ptr_q is written last and wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      pos         = 0;
      for (int i = N - 1; i >= 0; i--) begin
         pos = int'(ptr_q) + i;
         if (pos >= N) pos = pos - N;
         cand = IW'(pos);
         if (req[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         ptr_q <= '0;
      end else if (advance && grant_valid) begin
         ptr_q <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/winograd_kernel_scheduler.sv
// rtl/winograd_kernel_scheduler.sv - fetches 4x4 kernel tiles per channel for the Winograd core
// Optional shadow-slot prefetch: WINO_KSCHED_PREFETCH_EN
module winograd_kernel_scheduler
   import wino_sched_pkg::*;
#(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int N_CHANNELS  = 3,
   parameter int N_KERNELS   = 64,
   parameter int KERNEL_SIZE = 4,
   parameter int N_WINDOWS   = 169,
   parameter int KERNEL_BASE = 0
) (
   input  logic                  clock_i,
   input  logic                  reset_ni,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  mem_req_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic [DATA_WIDTH-1:0] mem_data_i,
   output logic [N_CHANNELS-1:0] kernel_valid_o,
   output logic [N_CHANNELS-1:0][KERNEL_SIZE*KERNEL_SIZE-1:0][DATA_WIDTH-1:0] kernel_o,
   input  logic [N_CHANNELS-1:0] hold_kernel_i
);

   localparam int TILE_WORDS = KERNEL_SIZE * KERNEL_SIZE;
   localparam int WW         = (TILE_WORDS > 1) ? $clog2(TILE_WORDS) : 1;
   localparam int CW         = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
   localparam int KW         = (N_KERNELS > 1) ? $clog2(N_KERNELS) : 1;
   localparam int TOTAL      = N_WINDOWS * N_KERNELS;
   localparam int LW         = $clog2(TOTAL + 1);

   sched_state_e state_q, state_d;

   logic [CW-1:0]         chan_q;
   logic [WW-1:0]         req_cnt_q;
   logic                  wr_en_q;
   logic [WW-1:0]         wr_word_q;
   logic [N_CHANNELS-1:0] valid_q;
   logic [N_CHANNELS-1:0] armed_q;
   logic [KW-1:0]         kidx_q  [N_CHANNELS];
   logic [LW-1:0]         loads_q [N_CHANNELS];
   logic [N_CHANNELS-1:0][TILE_WORDS-1:0][DATA_WIDTH-1:0] act_q;
`ifdef WINO_KSCHED_PREFETCH_EN
   logic [N_CHANNELS-1:0][TILE_WORDS-1:0][DATA_WIDTH-1:0] shadow_q;
   logic [N_CHANNELS-1:0] shadow_full_q;
   logic                  fill_active_q;
`endif

   logic [N_CHANNELS-1:0] arb_req;
   logic                  all_loaded;
   logic                  all_empty;
   logic                  grant_valid;
   logic [CW-1:0]         grant_idx;

   always_comb begin
      arb_req    = '0;
      all_loaded = 1'b1;
      for (int c = 0; c < N_CHANNELS; c++) begin
         if (loads_q[c] != '0) all_loaded = 1'b0;
`ifdef WINO_KSCHED_PREFETCH_EN
         arb_req[c] = (loads_q[c] != '0) && !shadow_full_q[c];
`else
         arb_req[c] = (loads_q[c] != '0) && !valid_q[c];
`endif
      end
   end

`ifdef WINO_KSCHED_PREFETCH_EN
   assign all_empty = (valid_q == '0) && (shadow_full_q == '0);
`else
   assign all_empty = (valid_q == '0);
`endif

   rr_arbiter #(.N(N_CHANNELS), .IW(CW)) u_arb (
      .clock_i     (clock_i),
      .reset_ni    (reset_ni),
      .req         (arb_req),
      .advance     (state_q == S_ARB),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (start_i) state_d = S_ARB;
         S_ARB: begin
            if (grant_valid)                  state_d = S_FETCH;
            else if (all_loaded && all_empty) state_d = S_DONE;
         end
         S_FETCH:     if (req_cnt_q == WW'(TILE_WORDS - 1)) state_d = S_WAIT_LAST;
         S_WAIT_LAST: state_d = S_ARB;
         S_DONE:      state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) state_q <= S_IDLE;
      else           state_q <= state_d;
   end

   assign busy_o         = (state_q != S_IDLE);
   assign done_o         = (state_q == S_DONE);
   assign mem_req_o      = (state_q == S_FETCH);
   assign mem_addr_o     = (state_q == S_FETCH)
                           ? ADDR_WIDTH'(tile_addr(32'(kidx_q[chan_q]), 32'(chan_q), 32'(N_CHANNELS),
                                                   32'(KERNEL_BASE), 32'(TILE_WORDS)) + 32'(req_cnt_q))
                           : '0;
   assign kernel_valid_o = valid_q;
   assign kernel_o       = act_q;

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         chan_q    <= '0;
         req_cnt_q <= '0;
         wr_en_q   <= 1'b0;
         wr_word_q <= '0;
         valid_q   <= '0;
         armed_q   <= '0;
         act_q     <= '0;
         for (int c = 0; c < N_CHANNELS; c++) begin
            kidx_q[c]  <= '0;
            loads_q[c] <= '0;
         end
`ifdef WINO_KSCHED_PREFETCH_EN
         shadow_q      <= '0;
         shadow_full_q <= '0;
         fill_active_q <= 1'b0;
`endif
      end else begin
         // Read data lags the request by one cycle, so the write side trails the request counter.
         wr_en_q   <= (state_q == S_FETCH);
         wr_word_q <= req_cnt_q;
         if (state_q == S_FETCH) req_cnt_q <= req_cnt_q + 1'b1;

         for (int c = 0; c < N_CHANNELS; c++) begin
            if (valid_q[c] && hold_kernel_i[c]) armed_q[c] <= 1'b1;
            if (armed_q[c] && !hold_kernel_i[c]) begin
               valid_q[c] <= 1'b0;
               armed_q[c] <= 1'b0;
            end
`ifdef WINO_KSCHED_PREFETCH_EN
            if (!valid_q[c] && shadow_full_q[c]) begin
               act_q[c]         <= shadow_q[c];
               valid_q[c]       <= 1'b1;
               shadow_full_q[c] <= 1'b0;
            end
`endif
         end

         if (wr_en_q) begin
`ifdef WINO_KSCHED_PREFETCH_EN
            if (fill_active_q) act_q[chan_q][wr_word_q]    <= mem_data_i;
            else               shadow_q[chan_q][wr_word_q] <= mem_data_i;
`else
            act_q[chan_q][wr_word_q] <= mem_data_i;
`endif
         end

         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  for (int c = 0; c < N_CHANNELS; c++) begin
                     kidx_q[c]  <= '0;
                     loads_q[c] <= LW'(TOTAL);
                  end
                  valid_q <= '0;
                  armed_q <= '0;
`ifdef WINO_KSCHED_PREFETCH_EN
                  shadow_full_q <= '0;
`endif
               end
            end
            S_ARB: begin
               if (grant_valid) begin
                  chan_q    <= grant_idx;
                  req_cnt_q <= '0;
`ifdef WINO_KSCHED_PREFETCH_EN
                  fill_active_q <= !valid_q[grant_idx];
`endif
               end
            end
            S_WAIT_LAST: begin
               kidx_q[chan_q]  <= (kidx_q[chan_q] == KW'(N_KERNELS - 1)) ? '0 : kidx_q[chan_q] + 1'b1;
               loads_q[chan_q] <= loads_q[chan_q] - 1'b1;
`ifdef WINO_KSCHED_PREFETCH_EN
               if (fill_active_q) valid_q[chan_q]       <= 1'b1;
               else               shadow_full_q[chan_q] <= 1'b1;
`else
               valid_q[chan_q] <= 1'b1;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule
